// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// the halt word, FSM state encoding and the default reset PC.
package ifu_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] HALT_WORD    = 32'h0000_000C;
    localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/ifu_if.sv
// Bus between the fetch unit and the rest of the datapath: control/operands in,
// PC, instruction and status out.
interface ifu_if;

    logic        stall;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] ext;
    logic [31:0] ra;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [15:0] imm;
    logic        valid;
    logic        halted;
    logic        addr_err;

    modport master (
        output stall, npc_op, br_taken, ext, ra,
        input  pc, pc4, instr, imm, valid, halted, addr_err
    );

    modport slave (
        input  stall, npc_op, br_taken, ext, ra,
        output pc, pc4, instr, imm, valid, halted, addr_err
    );

endinterface

// File: rtl/ifu_npc.sv
// Combinational next-PC selection: sequential, conditional branch, j/jal and jr.
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_npc_op,
    input  logic        i_br_taken,
    input  logic [31:0] i_ext,
    input  logic [31:0] i_ra,
    input  logic [25:0] i_jidx,
    output logic [31:0] o_pc4,
    output logic [31:0] o_npc
);

    logic [31:0] w_pc4;

    assign w_pc4 = i_pc + 32'd4;
    assign o_pc4 = w_pc4;

    always_comb begin
        o_npc = w_pc4;
        case (i_npc_op)
            NPC_SEQ: o_npc = w_pc4;
            NPC_BR:  o_npc = i_br_taken ? (w_pc4 + i_ext) : w_pc4;
            NPC_J:   o_npc = {w_pc4[31:28], i_jidx, 2'b00};
            NPC_JR:  o_npc = i_ra & 32'hFFFF_FFFC;
            default: o_npc = w_pc4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, instruction ROM and BOOT/RUN/HALT FSM.
// Define IFU_BOUND_CHECK_EN to trap out-of-range or misaligned next-PC values.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = DEF_PC_RESET,
    parameter int          IM_ADDR_W = 12,
    parameter              IM_FILE   = "code.txt"
)(
    input  logic clk,
    input  logic reset,
    ifu_if.slave bus
);

    localparam int ROM_DEPTH = 1 << IM_ADDR_W;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [31:0]            r_pc;
    logic [31:0]            w_pc_nxt;
    logic                   r_addr_err;
    logic                   w_err_set;
    logic [31:0]            r_rom [ROM_DEPTH];
    logic [IM_ADDR_W-1:0]   w_rom_idx;
    logic [31:0]            w_rom_word;
    logic [31:0]            w_npc;
    logic                   w_npc_bad;
    logic                   w_live;

    // r_rom is preloaded with the IM_FILE image by the build or simulation flow.
    if ($bits(IM_FILE) == 0) begin : g_no_image
    end

    // PC is always word aligned, so the word index is a narrow subtraction that wraps.
    assign w_rom_idx  = r_pc[IM_ADDR_W+1:2] - PC_RESET[IM_ADDR_W+1:2];
    assign w_rom_word = r_rom[w_rom_idx];
    assign w_live     = (r_state == ST_RUN);

    ifu_npc u_npc (
        .i_pc       (r_pc),
        .i_npc_op   (bus.npc_op),
        .i_br_taken (bus.br_taken),
        .i_ext      (bus.ext),
        .i_ra       (bus.ra),
        .i_jidx     (w_rom_word[25:0]),
        .o_pc4      (bus.pc4),
        .o_npc      (w_npc)
    );

`ifdef IFU_BOUND_CHECK_EN
    localparam logic [31:0] ROM_BYTES = 32'(4) << IM_ADDR_W;
    logic [31:0] w_npc_off;

    assign w_npc_off = w_npc - PC_RESET;
    assign w_npc_bad = (w_npc < PC_RESET) || (w_npc_off >= ROM_BYTES) ||
                       (w_npc[1:0] != 2'b00);
`else
    assign w_npc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= PC_RESET;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr_err <= r_addr_err | w_err_set;
        end
    end

    // Stall outranks both halt detection and the PC update.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_set   = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!bus.stall) begin
                    if (w_rom_word == HALT_WORD) begin
                        w_state_nxt = ST_HALT;
                    end else if (w_npc_bad) begin
                        w_state_nxt = ST_HALT;
                        w_err_set   = 1'b1;
                    end else begin
                        w_pc_nxt = w_npc;
                    end
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    assign bus.pc       = r_pc;
    assign bus.instr    = w_live ? w_rom_word : 32'h0;
    assign bus.imm      = bus.instr[15:0];
    assign bus.valid    = w_live;
    assign bus.halted   = (r_state == ST_HALT);
    assign bus.addr_err = r_addr_err;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed fetch/branch/jump/stall/halt/bound cases
// plus randomized control against a cycle-level behavioural model.
module tb_ifu;

    localparam logic [31:0] PC0   = 32'h0000_3000;
    localparam int          AW    = 12;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] HALTW = 32'h0000_000C;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ifu_if bus();

    ifu #(
        .PC_RESET  (PC0),
        .IM_ADDR_W (AW),
        .IM_FILE   ("code.txt")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_err;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rom_put(input int idx, input logic [31:0] word);
        mem[idx] = word;
        dut.r_rom[idx] = word;
    endtask

    function automatic logic [31:0] rom_at(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - PC0;
        return mem[int'((off >> 2) % DEPTH)];
    endfunction

    function automatic logic [31:0] exp_instr();
        return (m_mode == M_RUN) ? rom_at(m_pc) : 32'h0;
    endfunction

    task automatic check_all(input string where);
        logic [31:0] ei;
        ei = exp_instr();
        check({where, ".pc"},       bus.pc,               m_pc);
        check({where, ".pc4"},      bus.pc4,              m_pc + 32'd4);
        check({where, ".instr"},    bus.instr,            ei);
        check({where, ".imm"},      {16'h0, bus.imm},     ei & 32'h0000_FFFF);
        check({where, ".valid"},    {31'h0, bus.valid},   (m_mode == M_RUN)  ? 32'd1 : 32'd0);
        check({where, ".halted"},   {31'h0, bus.halted},  (m_mode == M_HALT) ? 32'd1 : 32'd0);
        check({where, ".addr_err"}, {31'h0, bus.addr_err}, {31'h0, m_err});
    endtask

    // Behavioural model of one rising edge, from the architectural rules.
    task automatic model_edge();
        logic [31:0] word, seq, tgt;
        if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && !bus.stall) begin
            word = rom_at(m_pc);
            seq  = m_pc + 32'd4;
            if (word == HALTW) begin
                m_mode = M_HALT;
            end else begin
                case (bus.npc_op)
                    2'd1:    tgt = bus.br_taken ? seq + bus.ext : seq;
                    2'd2:    tgt = (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
                    2'd3:    tgt = bus.ra & ~32'd3;
                    default: tgt = seq;
                endcase
`ifdef IFU_BOUND_CHECK_EN
                if (tgt < PC0 || tgt >= PC0 + 32'(4 * DEPTH) || tgt[1:0] != 2'b00) begin
                    m_err  = 1'b1;
                    m_mode = M_HALT;
                end else begin
                    m_pc = tgt;
                end
`else
                m_pc = tgt;
`endif
            end
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] op, input logic br,
                         input logic [31:0] ex, input logic [31:0] r);
        bus.stall    = st;
        bus.npc_op   = op;
        bus.br_taken = br;
        bus.ext      = ex;
        bus.ra       = r;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset is dropped mid-cycle and checked before any clock edge arrives.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset  = 1'b0;
        m_mode = M_BOOT;
        m_pc   = PC0;
        m_err  = 1'b0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("boot");
    endtask

    initial begin
        logic [31:0] w;
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if (w == HALTW) w = 32'h1234_5678;
            rom_put(i, w);
        end
        rom_put(4, 32'h0800_0C10);

        // Reset release, sequential fetch, branch both ways, jr, j, stall.
        do_reset();
        step("seq0");
        check("first_pc", bus.pc, 32'h0000_3000);
        step("seq1");
        step("seq2");
        check("seq_pc", bus.pc, 32'h0000_3008);
        drive(1'b0, 2'd1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        step("br_nt");
        check("br_not_taken", bus.pc, 32'h0000_300C);
        drive(1'b0, 2'd3, 1'b0, 32'h0, 32'h0000_300B);
        step("jr_back");
        drive(1'b0, 2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0);
        step("br_t");
        check("br_taken", bus.pc, 32'h0000_3004);
        drive(1'b0, 2'd3, 1'b0, 32'h0, 32'h0000_3010);
        step("jr_3010");
        drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        step("j");
        check("j_target", bus.pc, 32'h0000_3040);
        drive(1'b0, 2'd3, 1'b0, 32'h0, 32'h0000_3023);
        step("jr");
        check("jr_target", bus.pc, 32'h0000_3020);
        drive(1'b1, 2'd1, 1'b1, 32'h0000_0010, 32'h0);
        for (int i = 0; i < 3; i++) step("stall");
        check("stall_hold", bus.pc, 32'h0000_3020);
        drive(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0);
        step("resume");
        check("resume_pc", bus.pc, 32'h0000_3034);

        // Randomized control traffic.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
                  32'($urandom_range(0, 31) * 4) - 32'd64,
                  PC0 + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3)));
            step("rand");
            if (m_mode == M_HALT) do_reset();
        end

        // Halt word at 0x300C, stall priority, absorbing HALT, async exit.
        rom_put(3, HALTW);
        do_reset();
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step("to_halt");
        check("halt_fetch", bus.instr, HALTW);
        drive(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        step("halt_stall");
        check("halt_stall_valid", {31'h0, bus.valid}, 32'd1);
        drive(1'b0, 2'd3, 1'b0, 32'h0, 32'h0000_3100);
        step("halt");
        check("halted", {31'h0, bus.halted}, 32'd1);
        check("halt_instr", bus.instr, 32'h0);
        check("halt_pc", bus.pc, 32'h0000_300C);
        drive(1'b0, 2'd1, 1'b1, 32'h0000_0040, 32'h0);
        step("halt_hold");
        step("halt_hold");
        do_reset();
        check("async_rst_pc", bus.pc, 32'h0000_3000);
        rom_put(3, 32'h2000_0003);

        // jr just below the ROM base.
        do_reset();
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        step("pre_bound");
        drive(1'b0, 2'd3, 1'b0, 32'h0, 32'h0000_2FFC);
        step("bound");
`ifdef IFU_BOUND_CHECK_EN
        check("bound_err", {31'h0, bus.addr_err}, 32'd1);
        check("bound_halt", {31'h0, bus.halted}, 32'd1);
        check("bound_pc", bus.pc, 32'h0000_3000);
`else
        check("wrap_pc", bus.pc, 32'h0000_2FFC);
        check("wrap_instr", bus.instr, mem[DEPTH - 1]);
        check("wrap_err", {31'h0, bus.addr_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit of the single-cycle MIPS datapath, directly upstream of the immediate extender. Holds the PC, reads the instruction ROM, and presents the instruction and its 16-bit immediate to the extender. Consumes the extender's shifted, sign-extended branch offset (EOp=2'b11) and the decode/ALU results to form the next PC. A small control FSM provides a boot cycle after reset and a terminal halt.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset; base address of the ROM.
- IM_ADDR_W, 12, ROM word-address width (4096 words).
- IM_FILE, "code.txt", hex image loaded into the ROM at elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- npc_op  in  2  next-PC select: 00 sequential, 01 branch, 10 j/jal, 11 jr.
- br_taken  in  1  branch condition from ALU; used only when npc_op=01.
- ext  in  32  branch offset from extender, already sign-extended and <<2.
- ra  in  32  jr target register value.
- pc  out  32  current PC.
- pc4  out  32  pc+4 (jal link value).
- instr  out  32  current instruction.
- imm  out  16  instr[15:0], to extender.
- valid  out  1  instr is live and may be executed.
- halted  out  1  FSM in HALT.
- addr_err  out  1  sticky out-of-range fetch flag.

## Operation
- FSM states: BOOT, RUN, HALT.
  - reset low: state=BOOT, pc=PC_RESET, addr_err=0.
  - BOOT -> RUN unconditionally on the first rising edge after reset release; PC not updated in BOOT.
  - RUN -> HALT when the current instr equals 32'h0000_000C (halt word) and stall=0; PC is frozen.
  - HALT is absorbing; only reset exits.
- Outputs: valid = (state==RUN); halted = (state==HALT). In BOOT and HALT, instr is forced to 32'h0 (nop) and imm=16'h0.
- ROM index: (pc - PC_RESET)[IM_ADDR_W+1:2]; read is combinational.
- Next PC in RUN with stall=0:
  - 00: pc+4.
  - 01: br_taken ? pc+4+ext : pc+4.
  - 10: {pc4[31:28], instr[25:0], 2'b00}.
  - 11: {ra[31:2], 2'b00}.
- All adds are 32-bit modulo 2^32; carry discarded.
- stall=1 holds the PC and the state, and has priority over npc_op and over halt detection.
- Reset asserted mid-operation: pc, state and addr_err return to their reset values immediately (asynchronous).

## Timing
- instr, imm and pc4 are combinational from pc; zero latency within the cycle.
- A new PC becomes visible one clock after the edge at which it is computed.
- Taken branches and jumps have no delay slot and no bubble.
- First valid fetch is at PC_RESET, in the second cycle after reset release (the first cycle is BOOT).
- halted rises in the cycle after the halt word is fetched; pc stays at the halt word's address.

## Configuration
- IFU_BOUND_CHECK_EN defined:
  - If the computed next PC is outside [PC_RESET, PC_RESET + 4·2^IM_ADDR_W), or its low two bits are nonzero, the PC is not updated, addr_err is set, and the FSM enters HALT.
- Undefined:
  - No range check; the ROM index wraps modulo 2^IM_ADDR_W.
  - addr_err is tied to 0.

## Structure
- Shared package holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR codes.
  - HALT_WORD.
  - FSM state encoding.
  - default PC_RESET.
- One sub-module, npc: purely combinational next-PC computation from pc, npc_op, br_taken, ext, ra and instr[25:0]. The ifu top holds the PC register, ROM and FSM.

## Test plan
- Reset release: valid=0 for 1 cycle, then pc=0x3000; pc increments 0x3000→0x3004→0x3008 with npc_op=00.
- Branch at pc=0x3008, ext=0xFFFF_FFF8, br_taken=1 → next pc=0x3004. Same cycle with br_taken=0 → next pc=0x300C.
- j with instr[25:0]=0x0000C10 at pc=0x3010 → next pc=0x0000_3040. jr with ra=0x0000_3023 → next pc=0x3020.
- stall=1 for 3 cycles with npc_op=01 and br_taken=1 → pc unchanged throughout; resumes on the first cycle with stall=0.
- ROM holds 0x0000_000C at 0x300C → halted=1, valid=0, instr=0 from the next cycle; pc stays at 0x300C. Async reset pulse → pc=0x3000 without a clock edge.
- With IFU_BOUND_CHECK_EN: jr with ra=0x0000_2FFC → addr_err=1, halted=1, pc unchanged. Without the macro: pc=0x2FFC, and the ROM index wraps to 4095.
